// File: rtl/add_pkg.sv
// Shared sizes, FSM state type and counter-width helper for add_operand_loader.
package add_pkg;

  localparam int unsigned ADD_N     = 256;
  localparam int unsigned ADD_W     = 32;
  localparam int unsigned ADD_BEATS = ADD_N / ADD_W;

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    SETTLE,
    DONE
  } loader_state_t;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned ADD_CNT_W = cnt_width(ADD_BEATS);

endpackage

// File: rtl/add_operand_loader_if.sv
// Beat input, adder drive/return and result port of add_operand_loader.
// ADD_LOADER_OVF_EN adds the res_ovf signal.
interface add_operand_loader_if
  import add_pkg::*;
#(
  parameter int unsigned N = ADD_N,
  parameter int unsigned W = ADD_W
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_cin;

  logic [N-1:0] add_a;
  logic [N-1:0] add_b;
  logic         add_cin;
  logic [N-1:0] add_s;
  logic         add_cout;

  logic         res_valid;
  logic         res_ready;
  logic [N-1:0] res_sum;
  logic         res_cout;
`ifdef ADD_LOADER_OVF_EN
  logic         res_ovf;
`endif

  // Loader side.
  modport master (
`ifdef ADD_LOADER_OVF_EN
    output res_ovf,
`endif
    input  in_valid, in_data, in_cin, add_s, add_cout, res_ready,
    output in_ready, add_a, add_b, add_cin, res_valid, res_sum, res_cout
  );

  // Environment side: beat source, adder and result consumer.
  modport slave (
`ifdef ADD_LOADER_OVF_EN
    input  res_ovf,
`endif
    output in_valid, in_data, in_cin, add_s, add_cout, res_ready,
    input  in_ready, add_a, add_b, add_cin, res_valid, res_sum, res_cout
  );

endinterface

// File: rtl/beat_packer.sv
// Assembles an N-bit word from LSB-first W-bit beats; flags the final beat.
module beat_packer
  import add_pkg::*;
#(
  parameter int unsigned N = ADD_N,
  parameter int unsigned W = ADD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] data,
  output logic [N-1:0] value,
  output logic         last_c
);

  localparam int unsigned BEATS = N / W;
  localparam int unsigned CW    = cnt_width(BEATS);

  logic [CW-1:0] cnt;

  assign last_c = (cnt == CW'(BEATS - 1));

  // Write the beat into its slot; the counter wraps to 0 after the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      value <= '0;
    end else if (wr_en) begin
      for (int unsigned k = 0; k < BEATS; k++) begin
        if (cnt == CW'(k)) value[k*W +: W] <= data;
      end
      cnt <= last_c ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/add_operand_loader.sv
// Loads two N-bit operands from W-bit beats into an external combinational
// adder, waits SETTLE cycles, then registers and offers sum/cout.
// Optional macro: ADD_LOADER_OVF_EN adds registered signed overflow res_ovf.
module add_operand_loader
  import add_pkg::*;
#(
  parameter int unsigned N      = ADD_N,
  parameter int unsigned W      = ADD_W,
  parameter int unsigned SETTLE = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  add_operand_loader_if.master   bus
);

  localparam int unsigned SCW = cnt_width(SETTLE);

  if ((N % W) != 0) begin : g_bad_width
    $error("add_operand_loader: N must be a multiple of W");
  end
  if (SETTLE < 1) begin : g_bad_settle
    $error("add_operand_loader: SETTLE must be at least 1");
  end

  loader_state_t  state;
  loader_state_t  state_next;
  logic [SCW-1:0] settle_cnt;
  logic [SCW-1:0] settle_d;
  logic           accept_c;
  logic           a_wr_c;
  logic           b_wr_c;
  logic           a_last_c;
  logic           b_last_c;
  logic           in_ready_d;
  logic           add_cin_d;
  logic           res_valid_d;
  logic [N-1:0]   res_sum_d;
  logic           res_cout_d;
`ifdef ADD_LOADER_OVF_EN
  logic           res_ovf_d;
`endif

  assign accept_c = bus.in_valid & bus.in_ready;
  assign a_wr_c   = accept_c & (state == LOAD_A);
  assign b_wr_c   = accept_c & (state == LOAD_B);

  beat_packer #(.N(N), .W(W)) u_pack_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (a_wr_c),
    .data   (bus.in_data),
    .value  (bus.add_a),
    .last_c (a_last_c)
  );

  beat_packer #(.N(N), .W(W)) u_pack_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (b_wr_c),
    .data   (bus.in_data),
    .value  (bus.add_b),
    .last_c (b_last_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD_A;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      LOAD_A:          if (a_wr_c && a_last_c) state_next = LOAD_B;
      LOAD_B:          if (b_wr_c && b_last_c) state_next = add_pkg::SETTLE;
      add_pkg::SETTLE: if (settle_cnt == '0) state_next = DONE;
      DONE:            if (bus.res_valid && bus.res_ready) state_next = LOAD_A;
      default:         state_next = LOAD_A;
    endcase
  end

  // Next values of registered outputs and the settle counter; hold by default.
  always_comb begin
    settle_d    = settle_cnt;
    add_cin_d   = bus.add_cin;
    res_valid_d = bus.res_valid;
    res_sum_d   = bus.res_sum;
    res_cout_d  = bus.res_cout;
`ifdef ADD_LOADER_OVF_EN
    res_ovf_d   = bus.res_ovf;
`endif
    in_ready_d  = (state_next == LOAD_A) || (state_next == LOAD_B);
    unique case (state)
      LOAD_B: begin
        if (b_wr_c && b_last_c) begin
          add_cin_d = bus.in_cin;
          settle_d  = SCW'(SETTLE - 1);
        end
      end
      add_pkg::SETTLE: begin
        if (settle_cnt == '0) begin
          res_valid_d = 1'b1;
          res_sum_d   = bus.add_s;
          res_cout_d  = bus.add_cout;
`ifdef ADD_LOADER_OVF_EN
          res_ovf_d   = (bus.add_a[N-1] == bus.add_b[N-1]) &&
                        (bus.add_s[N-1] != bus.add_a[N-1]);
`endif
        end else begin
          settle_d = settle_cnt - SCW'(1);
        end
      end
      DONE: begin
        if (bus.res_ready) res_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Output and settle-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt    <= '0;
      bus.in_ready  <= 1'b1;
      bus.add_cin   <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_sum   <= '0;
      bus.res_cout  <= 1'b0;
`ifdef ADD_LOADER_OVF_EN
      bus.res_ovf   <= 1'b0;
`endif
    end else begin
      settle_cnt    <= settle_d;
      bus.in_ready  <= in_ready_d;
      bus.add_cin   <= add_cin_d;
      bus.res_valid <= res_valid_d;
      bus.res_sum   <= res_sum_d;
      bus.res_cout  <= res_cout_d;
`ifdef ADD_LOADER_OVF_EN
      bus.res_ovf   <= res_ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_add_operand_loader.sv
// Scoreboard bench for add_operand_loader; models the downstream adder and
// predicts results from whole operands. Honours ADD_LOADER_OVF_EN.
module tb_add_operand_loader;
  import add_pkg::*;

  localparam int unsigned N          = ADD_N;
  localparam int unsigned W          = ADD_W;
  localparam int unsigned BEATS      = ADD_BEATS;
  localparam int unsigned SETTLE_CYC = 4;

  typedef logic [N:0] wide_t;
  typedef struct {
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc_cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  add_operand_loader_if #(.N(N), .W(W)) bus ();

  add_operand_loader #(.N(N), .W(W), .SETTLE(SETTLE_CYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Downstream ripple adder stand-in.
  assign {bus.add_cout, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + wide_t'(bus.add_cin);

  exp_t sb[$];
  exp_t cur;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   rr_mode  = 0;
  bit   held     = 0;
  bit   prev_hs  = 0;
  bit   stuck    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer ready: 0 = always ready, 1 = random, 2 = stalled.
  always begin
    case (rr_mode)
      0:       bus.res_ready = 1'b1;
      1:       bus.res_ready = 1'($urandom_range(0, 1));
      default: bus.res_ready = 1'b0;
    endcase
    @(posedge clk);
    #1;
  end

  task automatic chk(input string nm, input wide_t act, input wide_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [N-1:0] rnd();
    logic [N-1:0] v;
    for (int k = 0; k < N / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Result monitor: pops the scoreboard on each new result, then checks hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      held    = 0;
      prev_hs = 0;
    end else begin
      if (prev_hs) chk("res_valid_one_cycle", wide_t'(bus.res_valid), wide_t'(0));
      if (bus.res_valid) begin
        if (!held) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result: got res_valid=1 expected no pending operation");
          end else begin
            cur = sb.pop_front();
            chk("latency", wide_t'(cyc - cur.acc_cyc), wide_t'(SETTLE_CYC));
          end
          held = 1;
        end
        chk("res_sum", wide_t'(bus.res_sum), wide_t'(cur.sum));
        chk("res_cout", wide_t'(bus.res_cout), wide_t'(cur.cout));
`ifdef ADD_LOADER_OVF_EN
        chk("res_ovf", wide_t'(bus.res_ovf), wide_t'(cur.ovf));
`endif
        chk("in_ready_done", wide_t'(bus.in_ready), wide_t'(0));
      end else begin
        held = 0;
      end
      prev_hs = bus.res_valid && bus.res_ready;
    end
  end

  task automatic send_beat(input logic [W-1:0] d, input logic c, input int gap_pct, output int acc);
    acc = cyc;
    if (stuck) return;
    while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
      bus.in_valid = 1'b0;
      bus.in_data  = $urandom;
      bus.in_cin   = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_cin   = c;
    for (int t = 0; t <= 200; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        acc = cyc;
        break;
      end
      if (t == 200) begin
        checks++;
        failures++;
        stuck = 1;
        $display("FAIL beat_timeout: in_ready=0 for %0d cycles, expected 1", t);
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin, input int gap_pct);
    int acc;
    exp_t e;
    wide_t full;
    logic signed [N+1:0] sx;
    for (int k = 0; k < BEATS; k++)
      send_beat(a[k*W +: W], 1'($urandom_range(0, 1)), gap_pct, acc);
    for (int k = 0; k < BEATS; k++)
      send_beat(b[k*W +: W], (k == BEATS - 1) ? cin : 1'($urandom_range(0, 1)), gap_pct, acc);
    bus.in_valid = 1'b0;
    if (stuck) return;
    full      = {1'b0, a} + {1'b0, b} + wide_t'(cin);
    sx        = {{2{a[N-1]}}, a} + {{2{b[N-1]}}, b} + (N+2)'(cin);
    e.sum     = full[N-1:0];
    e.cout    = full[N];
    e.ovf     = (sx[N] != sx[N-1]);
    e.acc_cyc = acc;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    for (int t = 0; t <= 500; t++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.res_valid) break;
      if (t == 500) begin
        checks++;
        failures++;
        $display("FAIL drain_timeout: pending=%0d expected 0", sb.size());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_add_a"}, wide_t'(bus.add_a), wide_t'(0));
    chk({tag, "_add_b"}, wide_t'(bus.add_b), wide_t'(0));
    chk({tag, "_add_cin"}, wide_t'(bus.add_cin), wide_t'(0));
    chk({tag, "_res_sum"}, wide_t'(bus.res_sum), wide_t'(0));
    chk({tag, "_res_cout"}, wide_t'(bus.res_cout), wide_t'(0));
    chk({tag, "_res_valid"}, wide_t'(bus.res_valid), wide_t'(0));
    chk({tag, "_in_ready"}, wide_t'(bus.in_ready), wide_t'(1));
`ifdef ADD_LOADER_OVF_EN
    chk({tag, "_res_ovf"}, wide_t'(bus.res_ovf), wide_t'(0));
`endif
  endtask

  initial begin
    int acc;
    logic [N-1:0] max_pos;
    logic [N-1:0] min_neg;
    max_pos      = {1'b0, {(N-1){1'b1}}};
    min_neg      = {1'b1, {(N-1){1'b0}}};
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_cin   = 1'b0;

    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Small operands, back-to-back, consumer always ready.
    run_op(N'(1), N'(1), 1'b0, 0);
    // Full-length carry ripple.
    run_op({N{1'b1}}, '0, 1'b1, 0);
    wait_idle();

    // Beat gaps with the consumer stalled for ten cycles in DONE.
    rr_mode = 2;
    run_op(rnd(), rnd(), 1'($urandom_range(0, 1)), 40);
    for (int t = 0; t <= 100; t++) begin
      @(negedge clk);
      if (bus.res_valid) break;
      if (t == 100) begin
        checks++;
        failures++;
        $display("FAIL result_timeout: res_valid=0 expected 1");
      end
    end
    repeat (10) @(posedge clk);
    #1;
    rr_mode = 0;
    run_op(rnd(), rnd(), 1'($urandom_range(0, 1)), 40);
    wait_idle();

    // Asynchronous reset after five a beats discards the partial load.
    for (int k = 0; k < 5; k++) send_beat($urandom | 32'h1, 1'b0, 0, acc);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op(rnd(), rnd(), 1'b1, 0);

    // Signed overflow corners.
    run_op(max_pos, N'(1), 1'b0, 0);
    run_op(min_neg, min_neg, 1'b0, 0);
    wait_idle();

    // Randomised operands, gaps and consumer backpressure.
    rr_mode = 1;
    for (int i = 0; i < 20; i++)
      run_op(rnd(), rnd(), 1'($urandom_range(0, 1)), $urandom_range(0, 30));
    rr_mode = 0;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
